// File: rtl/csr_priv_exec.sv
// Serialised executor for decoded CSR / privileged operations: CSR access,
// TLB and cache-maintenance handshakes, ERTN and IDLE, one op in flight.
module csr_priv_exec #(
    parameter int CSR_NUM_W = 14,
    parameter int XLEN      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_op,
    input  logic [CSR_NUM_W-1:0] in_csr_num,
    input  logic [XLEN-1:0]      in_rd_val,
    input  logic [XLEN-1:0]      in_rj_val,
    input  logic                 flush,
    output logic                 csr_re,
    output logic                 csr_we,
    output logic [CSR_NUM_W-1:0] csr_num,
    output logic [XLEN-1:0]      csr_wdata,
    input  logic [XLEN-1:0]      csr_rdata,
    output logic                 tlb_req,
    output logic [2:0]           tlb_op,
    input  logic                 tlb_done,
    output logic                 cacop_req,
    input  logic                 cacop_ack,
    input  logic                 intr_pending,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_result,
    output logic                 out_wen,
    output logic                 out_ertn,
    output logic                 out_ine
);
    localparam logic [3:0] CSR_CSRRD     = 4'd1;
    localparam logic [3:0] CSR_CSRWR     = 4'd2;
    localparam logic [3:0] CSR_CSRXCHG   = 4'd3;
    localparam logic [3:0] CSR_CACOP     = 4'd4;
    localparam logic [3:0] CSR_TLBSRCH   = 4'd5;
    localparam logic [3:0] CSR_TLBRD     = 4'd6;
    localparam logic [3:0] CSR_TLBWR     = 4'd7;
    localparam logic [3:0] CSR_TLBFILL   = 4'd8;
    localparam logic [3:0] CSR_IDLE      = 4'd9;
    localparam logic [3:0] CSR_ERTN      = 4'd10;
    localparam logic [3:0] CSR_INVTLB    = 4'd11;
    localparam logic [3:0] INVALID_OP_4B = 4'hF;

    typedef enum logic [2:0] {
        ST_READY, ST_CSR, ST_WAIT_TLB, ST_WAIT_CACHE, ST_WAIT_INT, ST_DONE
    } state_t;

    state_t                r_state, w_next;
    logic [3:0]            r_op;
    logic [CSR_NUM_W-1:0]  r_csr_num;
    logic [XLEN-1:0]       r_rd_val, r_rj_val;
    logic                  r_killed;
    logic [XLEN-1:0]       r_out_result;
    logic                  r_out_wen, r_out_ertn, r_out_ine;
    logic                  w_accept;

    function automatic logic is_csr(input logic [3:0] op);
        return (op == CSR_CSRRD) || (op == CSR_CSRWR) || (op == CSR_CSRXCHG);
    endfunction

    function automatic logic is_tlb(input logic [3:0] op);
        return (op == CSR_TLBSRCH) || (op == CSR_TLBRD) || (op == CSR_TLBWR) ||
               (op == CSR_TLBFILL) || (op == CSR_INVTLB);
    endfunction

    function automatic logic is_invalid(input logic [3:0] op);
        return !(is_csr(op) || is_tlb(op) || (op == CSR_CACOP) ||
                 (op == CSR_IDLE) || (op == CSR_ERTN)) || (op == INVALID_OP_4B);
    endfunction

    function automatic logic [2:0] tlb_code(input logic [3:0] op);
        case (op)
            CSR_TLBSRCH: return 3'd0;
            CSR_TLBRD:   return 3'd1;
            CSR_TLBWR:   return 3'd2;
            CSR_TLBFILL: return 3'd3;
            default:     return 3'd4;
        endcase
    endfunction

    assign w_accept = in_valid && (r_state == ST_READY) && !flush;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_READY;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        csr_re    = 1'b0;
        csr_we    = 1'b0;
        csr_num   = '0;
        csr_wdata = '0;
        tlb_req   = 1'b0;
        tlb_op    = 3'd0;
        cacop_req = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_READY: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    if (is_csr(in_op))            w_next = ST_CSR;
                    else if (is_tlb(in_op))       w_next = ST_WAIT_TLB;
                    else if (in_op == CSR_CACOP)  w_next = ST_WAIT_CACHE;
                    else if (in_op == CSR_IDLE)   w_next = ST_WAIT_INT;
                    else                          w_next = ST_DONE;
                end
            end
            ST_CSR: begin
                csr_re  = 1'b1;
                csr_num = r_csr_num;
                csr_we  = ((r_op == CSR_CSRWR) || (r_op == CSR_CSRXCHG)) && !flush;
                if (r_op == CSR_CSRXCHG)
                    csr_wdata = (csr_rdata & ~r_rj_val) | (r_rd_val & r_rj_val);
                else if (r_op == CSR_CSRWR)
                    csr_wdata = r_rd_val;
                w_next = flush ? ST_READY : ST_DONE;
            end
            ST_WAIT_TLB: begin
                // A flushed request still runs to completion; only the result is dropped.
                tlb_req = 1'b1;
                tlb_op  = tlb_code(r_op);
                if (tlb_done) w_next = (r_killed || flush) ? ST_READY : ST_DONE;
            end
            ST_WAIT_CACHE: begin
                cacop_req = 1'b1;
                if (cacop_ack) w_next = (r_killed || flush) ? ST_READY : ST_DONE;
            end
            ST_WAIT_INT: begin
                if (flush)             w_next = ST_READY;
                else if (intr_pending) w_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = !flush;
                if (flush || out_ready) w_next = ST_READY;
            end
            default: w_next = ST_READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op      <= in_op;
            r_csr_num <= in_csr_num;
            r_rd_val  <= in_rd_val;
            r_rj_val  <= in_rj_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (w_next == ST_READY)) begin
            r_killed     <= 1'b0;
            r_out_result <= '0;
            r_out_wen    <= 1'b0;
            r_out_ertn   <= 1'b0;
            r_out_ine    <= 1'b0;
        end else if (w_accept) begin
            r_out_ertn <= (in_op == CSR_ERTN);
            r_out_ine  <= is_invalid(in_op);
        end else begin
            if (flush && ((r_state == ST_WAIT_TLB) || (r_state == ST_WAIT_CACHE)))
                r_killed <= 1'b1;
            if (r_state == ST_CSR) begin
                r_out_result <= csr_rdata;
                r_out_wen    <= 1'b1;
            end
        end
    end

    assign out_result = r_out_result;
    assign out_wen    = r_out_wen;
    assign out_ertn   = r_out_ertn;
    assign out_ine    = r_out_ine;
endmodule

// File: tb/tb_csr_priv_exec.sv
// Directed bench for csr_priv_exec: stimulus pushes expected writebacks,
// a negedge monitor pops and compares on each out_valid/out_ready handshake.
module tb_csr_priv_exec;
    localparam logic [3:0] OP_RD = 4'd1, OP_WR = 4'd2, OP_XCHG = 4'd3, OP_CACOP = 4'd4;
    localparam logic [3:0] OP_SRCH = 4'd5, OP_TLBWR = 4'd7, OP_FILL = 4'd8;
    localparam logic [3:0] OP_IDLE = 4'd9, OP_ERTN = 4'd10, OP_BAD = 4'hF;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush;
    logic [3:0]  in_op;
    logic [13:0] in_csr_num, csr_num;
    logic [31:0] in_rd_val, in_rj_val, csr_wdata, csr_rdata, out_result;
    logic        csr_re, csr_we, tlb_req, tlb_done, cacop_req, cacop_ack, intr_pending;
    logic [2:0]  tlb_op;
    logic        out_valid, out_ready, out_wen, out_ertn, out_ine;

    typedef struct packed {
        logic [31:0] result;
        logic        wen;
        logic        ertn;
        logic        ine;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    csr_priv_exec #(.CSR_NUM_W(14), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_csr_num(in_csr_num), .in_rd_val(in_rd_val),
        .in_rj_val(in_rj_val), .flush(flush), .csr_re(csr_re), .csr_we(csr_we),
        .csr_num(csr_num), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .tlb_req(tlb_req), .tlb_op(tlb_op), .tlb_done(tlb_done),
        .cacop_req(cacop_req), .cacop_ack(cacop_ack), .intr_pending(intr_pending),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_wen(out_wen), .out_ertn(out_ertn), .out_ine(out_ine)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_writeback: got result=%h wen=%b ertn=%b ine=%b, none expected",
                         out_result, out_wen, out_ertn, out_ine);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({out_result, out_wen, out_ertn, out_ine} !== e) begin
                    errors++;
                    $display("FAIL writeback: got result=%h wen=%b ertn=%b ine=%b, want result=%h wen=%b ertn=%b ine=%b",
                             out_result, out_wen, out_ertn, out_ine, e.result, e.wen, e.ertn, e.ine);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer one op for one edge; returns in cycle T+1.
    task automatic issue(input logic [3:0] op, input logic [13:0] num,
                         input logic [31:0] rd, input logic [31:0] rj);
        in_valid = 1'b1; in_op = op; in_csr_num = num; in_rd_val = rd; in_rj_val = rj;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic push(input logic [31:0] r, input logic w, input logic e, input logic i);
        exp_t x;
        x = '{result: r, wen: w, ertn: e, ine: i};
        exp_q.push_back(x);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_csr_num = '0; in_rd_val = '0;
        in_rj_val = '0; flush = 1'b0; csr_rdata = '0; tlb_done = 1'b0;
        cacop_ack = 1'b0; intr_pending = 1'b0; out_ready = 1'b1;
        cyc(); cyc();
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_outs", {out_valid, out_wen, out_ertn, out_ine, tlb_req, cacop_req, csr_we, csr_re}, 32'd0);
        chk("reset_result", out_result, 32'd0);
        rst = 1'b0;
        cyc();

        // CSRWR
        csr_rdata = 32'h1234_5678;
        push(32'h1234_5678, 1'b1, 1'b0, 1'b0);
        issue(OP_WR, 14'h006, 32'hDEAD_BEEF, 32'h0);
        chk("wr_re_we", {csr_re, csr_we}, 32'd3);
        chk("wr_num", 32'(csr_num), 32'h006);
        chk("wr_wdata", csr_wdata, 32'hDEAD_BEEF);
        cyc();
        chk("wr_valid_T2", 32'(out_valid), 32'd1);
        cyc();
        chk("wr_back_ready", 32'(in_ready), 32'd1);

        // CSRXCHG, then CSRRD back-to-back
        csr_rdata = 32'h1111_1111;
        push(32'h1111_1111, 1'b1, 1'b0, 1'b0);
        issue(OP_XCHG, 14'h010, 32'hFFFF_0000, 32'h00FF_FF00);
        chk("xchg_we", 32'(csr_we), 32'd1);
        chk("xchg_wdata", csr_wdata, 32'h11FF_0011);
        cyc();
        chk("xchg_valid", 32'(out_valid), 32'd1);
        cyc();
        csr_rdata = 32'hCAFE_0001;
        push(32'hCAFE_0001, 1'b1, 1'b0, 1'b0);
        issue(OP_RD, 14'h001, 32'h5555_5555, 32'h0);
        chk("rd_re_we", {csr_re, csr_we}, 32'd2);
        cyc();
        chk("rd_valid", 32'(out_valid), 32'd1);
        cyc();

        // TLBFILL, done after 3 cycles, out_ready held low 2 cycles
        out_ready = 1'b0;
        push(32'h0, 1'b0, 1'b0, 1'b0);
        issue(OP_FILL, 14'h0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("fill_req_op", {tlb_req, tlb_op}, 32'hB);
            cyc();
        end
        chk("fill_req_op_last", {tlb_req, tlb_op}, 32'hB);
        tlb_done = 1'b1;
        cyc();
        tlb_done = 1'b0;
        chk("fill_done", {out_valid, out_wen, tlb_req}, 32'h4);
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("fill_hold", {out_valid, in_ready, out_wen, tlb_req}, 32'h8);
        end
        out_ready = 1'b1;
        cyc();
        chk("fill_back_ready", 32'(in_ready), 32'd1);

        // TLBWR with done already high
        tlb_done = 1'b1;
        push(32'h0, 1'b0, 1'b0, 1'b0);
        issue(OP_TLBWR, 14'h0, 32'h0, 32'h0);
        chk("tlbwr_req_op", {tlb_req, tlb_op}, 32'hA);
        cyc();
        tlb_done = 1'b0;
        chk("tlbwr_one_req", {tlb_req, out_valid}, 32'd1);
        cyc();

        // IDLE, interrupt 10 cycles later
        push(32'h0, 1'b0, 1'b0, 1'b0);
        issue(OP_IDLE, 14'h0, 32'h0, 32'h0);
        for (int i = 0; i < 9; i++) begin
            chk("idle_wait", {out_valid, in_ready}, 32'd0);
            cyc();
        end
        intr_pending = 1'b1;
        cyc();
        intr_pending = 1'b0;
        chk("idle_valid", 32'(out_valid), 32'd1);
        cyc();

        // ERTN and invalid op
        push(32'h0, 1'b0, 1'b1, 1'b0);
        issue(OP_ERTN, 14'h0, 32'h0, 32'h0);
        chk("ertn_T1", {out_valid, out_ertn, out_ine}, 32'h6);
        cyc();
        push(32'h0, 1'b0, 1'b0, 1'b1);
        issue(OP_BAD, 14'h0, 32'h0, 32'h0);
        chk("ine_T1", {out_valid, out_ertn, out_ine, out_wen}, 32'hA);
        cyc();
        push(32'h0, 1'b0, 1'b0, 1'b1);
        issue(4'd0, 14'h0, 32'h0, 32'h0);
        chk("ine_op0", {out_valid, out_ine}, 32'h3);
        cyc();

        // flush in READY blocks accept
        in_valid = 1'b1; in_op = OP_ERTN; flush = 1'b1;
        cyc();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_ready_noaccept", {in_ready, out_valid}, 32'h2);

        // flush during ST_CSR of CSRWR
        issue(OP_WR, 14'h006, 32'hDEAD_BEEF, 32'h0);
        flush = 1'b1;
        #1;
        chk("flush_csr_we", 32'(csr_we), 32'd0);
        cyc();
        flush = 1'b0;
        chk("flush_csr_back", {in_ready, out_valid, out_wen}, 32'h4);
        cyc();

        // flush during CACOP wait, ack 2 cycles later
        issue(OP_CACOP, 14'h0, 32'h0, 32'h0);
        chk("cacop_req", 32'(cacop_req), 32'd1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("cacop_req_held", {cacop_req, in_ready}, 32'h2);
        cyc();
        chk("cacop_req_held2", {cacop_req, out_valid}, 32'h2);
        cacop_ack = 1'b1;
        cyc();
        cacop_ack = 1'b0;
        chk("cacop_killed", {in_ready, out_valid, cacop_req}, 32'h4);
        cyc();

        // rst during TLB wait
        issue(OP_SRCH, 14'h0, 32'h0, 32'h0);
        chk("srch_req_op", {tlb_req, tlb_op}, 32'h8);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_mid", {tlb_req, in_ready, out_valid, out_wen, out_ertn, out_ine}, 32'h10);
        chk("rst_mid_result", out_result, 32'd0);
        cyc(); cyc();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
